// File: rtl/vector_ex_unit.sv
// vector_ex_unit: EX stage doing 32-bit scalar ops in one edge or 24-lane byte ops
// over three falling-edge chunks of 8 lanes, with flush and async reset.
module vector_ex_unit (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    input  logic         VectorOp_in,
    input  logic [1:0]   ALUOp_in,
    input  logic [191:0] opA,
    input  logic [191:0] opB,
    input  logic [3:0]   RR_in,
    input  logic         RegSWrite_in,
    input  logic         RegVWrite_in,
    output logic         stall,
    output logic         out_valid,
    output logic [191:0] result,
    output logic [3:0]   RR_out,
    output logic         RegSWrite_out,
    output logic         RegVWrite_out
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_n;
    logic [1:0] cnt, cnt_n;
    logic [191:0] a_r, b_r;
    logic [127:0] acc;
    logic [63:0] chunk;
    logic [1:0] op_r;
    logic [3:0] rr_r;
    logic sw_r, vw_r, sw_o, vw_o, accept;

    function automatic logic [31:0] alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return op == 2'b00 ? a + b : op == 2'b01 ? a - b : op == 2'b10 ? a * b : a ^ b;
    endfunction

    assign accept = state != BUSY && in_valid && !flush;
    assign stall = state == BUSY;
    assign out_valid = state == DONE;
    assign RegSWrite_out = sw_o & out_valid;
    assign RegVWrite_out = vw_o & out_valid;

    // Low 8 bits of the 32-bit op equal the per-lane mod-256 result for all four ops.
    always_comb begin
        chunk = '0;
        for (int i = 0; i < 8; i++)
            chunk[8*i +: 8] = 8'(alu(op_r, {24'b0, a_r[64*cnt + 8*i +: 8]}, {24'b0, b_r[64*cnt + 8*i +: 8]}));
    end

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        if (flush) begin
            state_n = IDLE;
            cnt_n = '0;
        end else if (state == BUSY) begin
            state_n = cnt == 2'd2 ? DONE : BUSY;
            cnt_n = cnt == 2'd2 ? 2'd0 : cnt + 2'd1;
        end else if (in_valid) begin
            state_n = VectorOp_in ? BUSY : DONE;
            cnt_n = '0;
        end else begin
            state_n = IDLE;
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
        end
    end

    // Lanes build up in acc so result only changes when a whole operation completes.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            a_r <= '0;
            b_r <= '0;
            acc <= '0;
            op_r <= '0;
            rr_r <= '0;
            sw_r <= 1'b0;
            vw_r <= 1'b0;
            result <= '0;
            RR_out <= '0;
            sw_o <= 1'b0;
            vw_o <= 1'b0;
        end else if (accept) begin
            a_r <= opA;
            b_r <= opB;
            op_r <= ALUOp_in;
            rr_r <= RR_in;
            sw_r <= RegSWrite_in;
            vw_r <= RegVWrite_in;
            if (!VectorOp_in) begin
                result <= {160'b0, alu(ALUOp_in, opA[31:0], opB[31:0])};
                RR_out <= RR_in;
                sw_o <= RegSWrite_in;
                vw_o <= RegVWrite_in;
            end
        end else if (state == BUSY && !flush) begin
            if (cnt == 2'd2) begin
                result <= {chunk, acc};
                RR_out <= rr_r;
                sw_o <= sw_r;
                vw_o <= vw_r;
            end else begin
                acc[64*cnt[0] +: 64] <= chunk;
            end
        end
    end
endmodule
